// File: rtl/i2c_master_controller.sv
`default_nettype none
// ============================================================================
// Module      : i2c_master_controller
// Description : Single-byte open-drain I2C master (START, addr+R/W, one data
//               byte written or read, STOP). No clock stretching.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_master_controller #(
    parameter int QUARTER = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] addr,
    input  logic [7:0] data_in,
    input  logic       enable,
    input  logic       rw,
    output logic [7:0] data_out,
    output logic       ready,
    inout  wire        i2c_sda,
    inout  wire        i2c_scl
);

    localparam int C_QW = (QUARTER > 1) ? $clog2(QUARTER) : 1;
    localparam logic [C_QW-1:0] C_QLAST = C_QW'(QUARTER - 1);

    localparam logic [3:0] c_IDLE     = 4'd0;
    localparam logic [3:0] c_START    = 4'd1;
    localparam logic [3:0] c_ADDR     = 4'd2;
    localparam logic [3:0] c_ADDR_ACK = 4'd3;
    localparam logic [3:0] c_WR_DATA  = 4'd4;
    localparam logic [3:0] c_WR_ACK   = 4'd5;
    localparam logic [3:0] c_RD_DATA  = 4'd6;
    localparam logic [3:0] c_RD_NACK  = 4'd7;
    localparam logic [3:0] c_STOP     = 4'd8;

    logic [3:0]      r_state;
    logic [C_QW-1:0] r_qcnt;
    logic [1:0]      r_quarter;
    logic [2:0]      r_bit;
    logic [7:0]      r_addr_rw;
    logic [7:0]      r_wdata;
    logic [7:0]      r_rx;
    logic [7:0]      r_data_out;
    logic            r_ack;

    logic w_tick;
    logic w_sample;
    logic w_slot_end;
    logic w_sda_in;
    logic w_sda_low;
    logic w_scl_low;

    assign w_tick     = (r_qcnt == C_QLAST);
    assign w_sample   = w_tick && (r_quarter == 2'd2);
    assign w_slot_end = w_tick && (r_quarter == 2'd3);
    assign w_sda_in   = i2c_sda;

    assign ready    = (r_state == c_IDLE) & ~rst;
    assign data_out = r_data_out;

    // Line drive is decoded straight from state so reset releases the bus at once.
    always_comb begin
        w_sda_low = 1'b0;
        w_scl_low = 1'b0;
        case (r_state)
            c_START: begin
                w_sda_low = r_quarter[1];
            end
            c_ADDR: begin
                w_scl_low = ~r_quarter[1];
                w_sda_low = ~r_addr_rw[r_bit];
            end
            c_WR_DATA: begin
                w_scl_low = ~r_quarter[1];
                w_sda_low = ~r_wdata[r_bit];
            end
            c_ADDR_ACK, c_WR_ACK, c_RD_DATA, c_RD_NACK: begin
                w_scl_low = ~r_quarter[1];
            end
            c_STOP: begin
                w_scl_low = (r_quarter == 2'd0);
                w_sda_low = ~r_quarter[1];
            end
            default: begin
                w_sda_low = 1'b0;
                w_scl_low = 1'b0;
            end
        endcase
    end

    assign i2c_sda = w_sda_low ? 1'b0 : 1'bz;
    assign i2c_scl = w_scl_low ? 1'b0 : 1'bz;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_qcnt     <= '0;
            r_quarter  <= 2'd0;
            r_bit      <= 3'd7;
            r_addr_rw  <= 8'd0;
            r_wdata    <= 8'd0;
            r_rx       <= 8'd0;
            r_data_out <= 8'd0;
            r_ack      <= 1'b1;
        end else if (r_state == c_IDLE) begin
            r_qcnt    <= '0;
            r_quarter <= 2'd0;
            r_bit     <= 3'd7;
            if (enable) begin
                r_addr_rw <= {addr, rw};
                r_wdata   <= data_in;
                r_state   <= c_START;
            end
        end else begin
            if (!w_tick) begin
                r_qcnt <= r_qcnt + C_QW'(1);
            end else begin
                r_qcnt    <= '0;
                r_quarter <= w_slot_end ? 2'd0 : r_quarter + 2'd1;
            end

            if (w_sample) begin
                r_ack <= w_sda_in;
                if (r_state == c_RD_DATA) begin
                    r_rx <= {r_rx[6:0], w_sda_in};
                end
            end

            if (w_slot_end) begin
                case (r_state)
                    c_START: begin
                        r_state <= c_ADDR;
                        r_bit   <= 3'd7;
                    end
                    c_ADDR: begin
                        if (r_bit == 3'd0) r_state <= c_ADDR_ACK;
                        else               r_bit   <= r_bit - 3'd1;
                    end
                    c_ADDR_ACK: begin
                        r_bit <= 3'd7;
                        if (r_ack)             r_state <= c_STOP;
                        else if (r_addr_rw[0]) r_state <= c_RD_DATA;
                        else                   r_state <= c_WR_DATA;
                    end
                    c_WR_DATA: begin
                        if (r_bit == 3'd0) r_state <= c_WR_ACK;
                        else               r_bit   <= r_bit - 3'd1;
                    end
                    c_WR_ACK:  r_state <= c_STOP;
                    c_RD_DATA: begin
                        // r_rx already holds the 8th bit, shifted in at q2.
                        if (r_bit == 3'd0) begin
                            r_data_out <= r_rx;
                            r_state    <= c_RD_NACK;
                        end else begin
                            r_bit <= r_bit - 3'd1;
                        end
                    end
                    c_RD_NACK: r_state <= c_STOP;
                    c_STOP:    r_state <= c_IDLE;
                    default:   r_state <= c_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2c_master_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_master_controller
// Description : Self-checking bench: bus-level slave/monitor plus a timing model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_master_controller;

    localparam int         Q          = 1;
    localparam logic [6:0] SLAVE_ADDR = 7'h2A;
    localparam logic [7:0] SLAVE_BYTE = 8'hA5;
    localparam int         EV_START   = -1;
    localparam int         EV_STOP    = -2;

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic       enable  = 1'b0;
    logic       rw      = 1'b0;
    logic [6:0] addr    = 7'd0;
    logic [7:0] data_in = 8'd0;
    wire  [7:0] data_out;
    wire        ready;
    wire        sda_bus;
    wire        scl_bus;

    pullup (sda_bus);
    pullup (scl_bus);

    logic s_drv = 1'b0;
    assign sda_bus = s_drv ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_master_controller #(.QUARTER(Q)) dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .data_in  (data_in),
        .enable   (enable),
        .rw       (rw),
        .data_out (data_out),
        .ready    (ready),
        .i2c_sda  (sda_bus),
        .i2c_scl  (scl_bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Bus slave at SLAVE_ADDR plus event monitor, sampled once per clk.
    int         ev_log[$];
    logic       p_sda = 1'b1, p_scl = 1'b1, c_sda, c_scl;
    int         s_k = 0, nx;
    logic [7:0] s_addr = 8'd0, s_rx = 8'd0;
    logic [7:0] rd_byte = SLAVE_BYTE;
    logic       s_sel = 1'b0, s_rd = 1'b0;

    always @(negedge clk) begin
        c_sda = sda_bus;
        c_scl = scl_bus;
        if (p_scl && c_scl && p_sda && !c_sda) begin
            ev_log.push_back(EV_START);
            s_k = 0; s_sel = 1'b0; s_drv = 1'b0;
        end else if (p_scl && c_scl && !p_sda && c_sda) begin
            ev_log.push_back(EV_STOP);
            s_k = 0; s_drv = 1'b0;
        end else if (!p_scl && c_scl) begin
            ev_log.push_back(int'(c_sda));
            s_k++;
            if (s_k <= 8) s_addr = {s_addr[6:0], c_sda};
            if (s_sel && !s_rd && s_k >= 10 && s_k <= 17) s_rx = {s_rx[6:0], c_sda};
        end else if (p_scl && !c_scl) begin
            nx = s_k + 1;
            if (nx == 9) begin
                s_sel = (s_addr[7:1] == SLAVE_ADDR);
                s_rd  = s_addr[0];
                s_drv = s_sel;
            end else if (s_sel && !s_rd && nx == 18) begin
                s_drv = 1'b1;
            end else if (s_sel && s_rd && nx >= 10 && nx <= 17) begin
                s_drv = ~rd_byte[17 - nx];
            end else begin
                s_drv = 1'b0;
            end
        end
        p_sda = c_sda;
        p_scl = c_scl;
    end

    // Cycle model: a transaction is a fixed number of 4-quarter slots.
    int         m_left = 0, m_dur = 0, t, slot, q, nslot;
    logic       m_rd = 1'b0, m_acc, e_ready, e_scl;
    logic [7:0] m_dout = 8'd0;

    always @(negedge clk) begin
        if (rst) begin
            m_left = 0; m_dout = 8'd0; m_rd = 1'b0;
            e_ready = 1'b0; e_scl = 1'b1;
        end else if (m_left == 0) begin
            e_ready = 1'b1; e_scl = 1'b1;
        end else begin
            t     = m_dur - m_left;
            slot  = t / (4 * Q);
            q     = (t % (4 * Q)) / Q;
            nslot = m_dur / (4 * Q);
            e_ready = 1'b0;
            if (slot == 0)              e_scl = 1'b1;
            else if (slot == nslot - 1) e_scl = (q != 0);
            else                        e_scl = (q >= 2);
            if (m_rd && slot >= 18) m_dout = SLAVE_BYTE;
        end
        check("ready", ready, e_ready);
        check("scl", scl_bus, e_scl);
        check("data_out", data_out, m_dout);
        if (!rst) begin
            if (m_left > 0) begin
                m_left--;
            end else if (enable) begin
                m_acc  = (addr == SLAVE_ADDR);
                m_rd   = m_acc && rw;
                m_dur  = (m_acc ? 20 : 11) * 4 * Q;
                m_left = m_dur;
            end
        end
    end

    int exp_q[$];

    task automatic build_exp(input logic [6:0] a, input logic r, input logic [7:0] wd);
        logic [7:0] b;
        logic       ack;
        exp_q.delete();
        exp_q.push_back(EV_START);
        b = {a, r};
        for (int i = 7; i >= 0; i--) exp_q.push_back(int'(b[i]));
        ack = (a != SLAVE_ADDR);
        exp_q.push_back(int'(ack));
        if (!ack) begin
            b = r ? SLAVE_BYTE : wd;
            for (int i = 7; i >= 0; i--) exp_q.push_back(int'(b[i]));
            exp_q.push_back(r ? 1 : 0);
        end
        // STOP: SCL rises with SDA still low, then SDA rises.
        exp_q.push_back(0);
        exp_q.push_back(EV_STOP);
    endtask

    task automatic check_log(input string name);
        check({name, "_len"}, ev_log.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < ev_log.size(); i++)
            check(name, ev_log[i], exp_q[i]);
        ev_log.delete();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_txn(input logic [6:0] a, input logic r, input logic [7:0] wd,
                           output int busy);
        addr = a; rw = r; data_in = wd; enable = 1'b1;
        step();
        enable = 1'b0;
        busy = 0;
        while (!ready && busy < 300) begin
            step();
            busy++;
        end
        check("idle_timeout", ready, 1'b1);
    endtask

    int busy;

    initial begin
        // T1 reset
        repeat (10) step();
        check("rst_ready", ready, 1'b0);
        check("rst_dout", data_out, 8'h00);
        check("rst_sda", sda_bus, 1'b1);
        check("rst_scl", scl_bus, 1'b1);
        rst = 1'b0;
        step();
        check("ready_after_rst", ready, 1'b1);
        ev_log.delete();

        // T2 write
        run_txn(7'h2A, 1'b0, 8'hAA, busy);
        check("wr_busy", busy, 80);
        check("slv_addr", s_addr, 8'h54);
        check("slv_rx", s_rx, 8'hAA);
        build_exp(7'h2A, 1'b0, 8'hAA);
        check_log("wr_bus");

        // T3 read
        run_txn(7'h2A, 1'b1, 8'h00, busy);
        check("rd_busy", busy, 80);
        check("rd_data", data_out, 8'hA5);
        build_exp(7'h2A, 1'b1, 8'h00);
        check_log("rd_bus");

        // T4 address NACK
        run_txn(7'h11, 1'b0, 8'h3C, busy);
        check("nack_busy", busy, 44);
        check("nack_dout", data_out, 8'hA5);
        build_exp(7'h11, 1'b0, 8'h3C);
        check_log("nack_bus");

        // T5 reset during the address phase
        addr = 7'h2A; rw = 1'b0; data_in = 8'hAA; enable = 1'b1;
        step();
        enable = 1'b0;
        repeat (14) step();
        rst = 1'b1;
        step();
        check("midrst_sda", sda_bus, 1'b1);
        check("midrst_scl", scl_bus, 1'b1);
        check("midrst_ready", ready, 1'b0);
        rst = 1'b0;
        step();
        check("midrst_idle", ready, 1'b1);
        ev_log.delete();
        run_txn(7'h2A, 1'b0, 8'hAA, busy);
        check("rewr_busy", busy, 80);
        build_exp(7'h2A, 1'b0, 8'hAA);
        check_log("rewr_bus");

        // T6 enable while busy is ignored
        addr = 7'h2A; rw = 1'b0; data_in = 8'h5C; enable = 1'b1;
        step();
        enable = 1'b0;
        repeat (20) step();
        addr = 7'h2A; rw = 1'b1; enable = 1'b1;
        step();
        enable = 1'b0;
        busy = 21;
        while (!ready && busy < 300) begin
            step();
            busy++;
        end
        check("busy_timeout", ready, 1'b1);
        repeat (10) step();
        check("busy_still_idle", ready, 1'b1);
        build_exp(7'h2A, 1'b0, 8'h5C);
        check_log("busy_bus");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
